// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if -- serial line in, deframer status/data out.
//   master : line side (drives RxEN, Rx; observes deframer outputs)
//   slave  : deframer side (samples RxEN, Rx; drives all Rx_* outputs)
//   RxEN, Rx                    : enable and serial bit, LSB first
//   Rx_FlagDetect/AbortDetect   : one-cycle pattern pulses
//   Rx_ValidFrame               : frame open
//   Rx_NewByte, Rx_Data         : byte strobe and held data byte
//   Rx_EoF, Rx_FrameError       : closing-flag pulse and misalignment pulse
//   Rx_FrameSize                : data-byte count of the frame
interface hdlc_rx_deframer_if;
  localparam int unsigned DataWidth = 8;

  logic                 RxEN;
  logic                 Rx;
  logic                 Rx_FlagDetect;
  logic                 Rx_AbortDetect;
  logic                 Rx_ValidFrame;
  logic                 Rx_NewByte;
  logic [DataWidth-1:0] Rx_Data;
  logic                 Rx_EoF;
  logic                 Rx_FrameError;
  logic [DataWidth-1:0] Rx_FrameSize;

  modport master (
    output RxEN, Rx,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
           Rx_Data, Rx_EoF, Rx_FrameError, Rx_FrameSize
  );

  modport slave (
    input  RxEN, Rx,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
           Rx_Data, Rx_EoF, Rx_FrameError, Rx_FrameSize
  );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer -- HDLC receive deframer: flag/abort detection, zero
// removal, byte assembly and frame state tracking.
//   Clk   : clock, rising edge
//   Rst   : asynchronous active-high reset
//   rxIf  : hdlc_rx_deframer_if.slave (RxEN/Rx in, Rx_* status/data out)
// Optional feature: define HDLC_RX_FRAMESIZE_EN to enable the Rx_FrameSize
// byte counter; otherwise Rx_FrameSize is tied to zero.
module hdlc_rx_deframer (
  input  logic              Clk,
  input  logic              Rst,
  hdlc_rx_deframer_if.slave rxIf
);
  localparam int unsigned DataWidth = 8;
  localparam int unsigned CntWidth  = 3;

  localparam logic [DataWidth-1:0] FlagPattern  = 8'h7E;
  localparam logic [DataWidth-1:0] AbortPattern = 8'hFE;
  localparam logic [DataWidth-1:0] IdlePattern  = 8'hFF;
  localparam logic [CntWidth-1:0]  GuardReload  = 3'd7;
  localparam logic [CntWidth-1:0]  OnesLimit    = 3'd5;
  localparam logic [CntWidth-1:0]  LastBit      = 3'd7;

  typedef enum logic [1:0] {HUNT, OPEN, DATA} rxState_t;

  rxState_t             state;
  logic [DataWidth-1:0] window;
  logic [DataWidth-1:0] shiftReg;
  logic [CntWidth-1:0]  guardCnt;
  logic [CntWidth-1:0]  onesCnt;
  logic [CntWidth-1:0]  bitCnt;

  logic                 flagDet;
  logic                 abortDet;
  logic                 validFrame;
  logic                 newByte;
  logic [DataWidth-1:0] dataReg;
  logic                 eofPulse;
  logic                 frameErr;

  logic                 flagMatch;
  logic                 abortMatch;
  logic                 idleMatch;
  logic                 inFrame;
  logic                 exitBit;
  logic                 takeBit;
  logic                 stuffedZero;
  logic                 dataBit;
  logic [DataWidth-1:0] nextByte;

  // Pattern matches on the window and classification of the bit leaving it
  assign flagMatch   = (window == FlagPattern);
  assign abortMatch  = (window == AbortPattern);
  assign idleMatch   = (window == IdlePattern);
  assign inFrame     = (state != HUNT);
  assign exitBit     = window[0];
  // The exit bit in a match cycle is the first pattern bit, so it is dropped
  // here and the guard drops the remaining seven.
  assign takeBit     = inFrame && (guardCnt == '0) && !flagMatch && !abortMatch && !idleMatch;
  assign stuffedZero = takeBit && (onesCnt == OnesLimit) && !exitBit;
  assign dataBit     = takeBit && !stuffedZero;
  assign nextByte    = {exitBit, shiftReg[DataWidth-1:1]};

  // Frame state, window, counters and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= HUNT;
      window     <= IdlePattern;
      shiftReg   <= '0;
      guardCnt   <= '0;
      onesCnt    <= '0;
      bitCnt     <= '0;
      flagDet    <= 1'b0;
      abortDet   <= 1'b0;
      validFrame <= 1'b0;
      newByte    <= 1'b0;
      dataReg    <= '0;
      eofPulse   <= 1'b0;
      frameErr   <= 1'b0;
    end else if (!rxIf.RxEN) begin
      state      <= HUNT;
      window     <= IdlePattern;
      guardCnt   <= '0;
      onesCnt    <= '0;
      bitCnt     <= '0;
      flagDet    <= 1'b0;
      abortDet   <= 1'b0;
      validFrame <= 1'b0;
      newByte    <= 1'b0;
      eofPulse   <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      window     <= {rxIf.Rx, window[DataWidth-1:1]};
      flagDet    <= flagMatch;
      abortDet   <= abortMatch;
      // Follows the state one cycle late so it is still high with the abort pulse
      validFrame <= inFrame;
      newByte    <= 1'b0;
      eofPulse   <= 1'b0;
      frameErr   <= 1'b0;
      if (guardCnt != '0) begin
        guardCnt <= guardCnt - 3'd1;
      end

      if (flagMatch || abortMatch) begin
        guardCnt <= GuardReload;
        onesCnt  <= '0;
        bitCnt   <= '0;
      end

      if (flagMatch) begin
        if (state == DATA) begin
          eofPulse <= 1'b1;
          frameErr <= (bitCnt != '0);
        end
        state <= OPEN;
      end else if (abortMatch) begin
        state <= HUNT;
      end else if (idleMatch && inFrame) begin
        state   <= HUNT;
        onesCnt <= '0;
        bitCnt  <= '0;
      end else if (stuffedZero) begin
        onesCnt <= '0;
      end else if (dataBit) begin
        if (state == OPEN) begin
          state <= DATA;
        end
        if (exitBit) begin
          onesCnt <= (onesCnt == OnesLimit) ? onesCnt : onesCnt + 3'd1;
        end else begin
          onesCnt <= '0;
        end
        shiftReg <= nextByte;
        bitCnt   <= bitCnt + 3'd1;
        if (bitCnt == LastBit) begin
          dataReg <= nextByte;
          newByte <= 1'b1;
        end
      end
    end
  end

  assign rxIf.Rx_FlagDetect  = flagDet;
  assign rxIf.Rx_AbortDetect = abortDet;
  assign rxIf.Rx_ValidFrame  = validFrame;
  assign rxIf.Rx_NewByte     = newByte;
  assign rxIf.Rx_Data        = dataReg;
  assign rxIf.Rx_EoF         = eofPulse;
  assign rxIf.Rx_FrameError  = frameErr;

`ifdef HDLC_RX_FRAMESIZE_EN
  logic [DataWidth-1:0] frameSize;
  logic                 sizeClear;
  logic                 sizeIncr;

  // Cleared when a new frame starts (opening from HUNT or first data bit
  // after a closing flag); held from the closing flag onward.
  assign sizeClear = (flagMatch && (state == HUNT)) || (dataBit && (state == OPEN));
  assign sizeIncr  = dataBit && (bitCnt == LastBit);

  // Saturating data-byte counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      frameSize <= '0;
    end else if (!rxIf.RxEN) begin
      frameSize <= '0;
    end else if (sizeClear) begin
      frameSize <= '0;
    end else if (sizeIncr && (frameSize != 8'hFF)) begin
      frameSize <= frameSize + 8'd1;
    end
  end

  assign rxIf.Rx_FrameSize = frameSize;
`else
  assign rxIf.Rx_FrameSize = '0;
`endif
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer -- directed bench for hdlc_rx_deframer: frames are
// sent bit by bit, pulses are tallied on the falling edge, and tallies and
// sampled outputs are compared with hand-computed values.
module tb_hdlc_rx_deframer;
  logic Clk = 1'b0;
  logic Rst;

  hdlc_rx_deframer_if bus ();

  hdlc_rx_deframer dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .rxIf (bus.slave)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nPassed = 0;
  int cyc = 0;
  int flagCnt = 0, abortCnt = 0, eofCnt = 0, errCnt = 0, errAlone = 0, overlapCnt = 0;
  int flagCyc = 0, eofCyc = 0, closeCyc = 0;
  int txOnes = 0;
  logic [7:0] lastSize = 8'h00;
  logic       lastErr = 1'b0;
  logic [7:0] byteQ[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse tally, sampled mid-cycle
  always @(negedge Clk) begin
    if (bus.Rx_FlagDetect) begin flagCnt++; flagCyc = cyc; end
    if (bus.Rx_AbortDetect) abortCnt++;
    if (bus.Rx_NewByte) byteQ.push_back(bus.Rx_Data);
    if (bus.Rx_FlagDetect && bus.Rx_NewByte) overlapCnt++;
    if (bus.Rx_FrameError) errCnt++;
    if (bus.Rx_FrameError && !bus.Rx_EoF) errAlone++;
    if (bus.Rx_EoF) begin
      eofCnt++; eofCyc = cyc; lastErr = bus.Rx_FrameError; lastSize = bus.Rx_FrameSize;
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [31:0] expSize(input int n);
`ifdef HDLC_RX_FRAMESIZE_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  function automatic logic [31:0] qByte(input int i);
    if (i < byteQ.size()) return 32'(byteQ[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clearCounts();
    flagCnt = 0; abortCnt = 0; eofCnt = 0; errCnt = 0; errAlone = 0;
    lastErr = 1'b0; lastSize = 8'h00;
    byteQ.delete();
  endtask

  task automatic sendBit(input logic b);
    bus.Rx = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic sendRaw(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendBit(v[i]);
    txOnes = 0;
  endtask

  // Sends a data byte LSB first with zero insertion after five 1s
  task automatic sendData(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      sendBit(v[i]);
      if (v[i]) begin
        txOnes++;
        if (txOnes == 5) begin
          sendBit(1'b0);
          txOnes = 0;
        end
      end else begin
        txOnes = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b1);
  endtask

  initial begin
    logic [11:0] oddBits;
    oddBits = 12'h53C;

    Rst = 1'b1;
    bus.RxEN = 1'b1;
    bus.Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkEq("rst_valid", 32'(bus.Rx_ValidFrame), 32'd0);
    checkEq("rst_data", 32'(bus.Rx_Data), 32'h00);
    checkEq("rst_size", 32'(bus.Rx_FrameSize), 32'h00);
    checkEq("rst_pulses", 32'({bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte,
                               bus.Rx_EoF, bus.Rx_FrameError}), 32'd0);
    Rst = 1'b0;

    // First flag straight after reset release; latency t+2 only
    sendRaw(8'h7E);
    checkEq("flag_t1", 32'(bus.Rx_FlagDetect), 32'd0);
    sendBit(1'b1);
    checkEq("flag_t2", 32'(bus.Rx_FlagDetect), 32'd1);
    sendBit(1'b1);
    checkEq("flag_t3", 32'(bus.Rx_FlagDetect), 32'd0);
    checkEq("valid_open", 32'(bus.Rx_ValidFrame), 32'd1);
    idle(12);

    // Two-byte frame
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'hA5);
    sendData(8'h3C);
    sendRaw(8'h7E);
    closeCyc = cyc;
    idle(12);
    checkEq("two_flags", 32'(flagCnt), 32'd2);
    checkEq("two_nbytes", 32'(byteQ.size()), 32'd2);
    checkEq("two_byte0", qByte(0), 32'hA5);
    checkEq("two_byte1", qByte(1), 32'h3C);
    checkEq("two_eof", 32'(eofCnt), 32'd1);
    checkEq("two_eof_lat", 32'(eofCyc), 32'(closeCyc + 1));
    checkEq("two_err", 32'(errCnt), 32'd0);
    checkEq("two_size", 32'(lastSize), expSize(2));

    // Zero removal: 0xFF goes out as 11111 0 111
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'hFF);
    sendRaw(8'h7E);
    idle(12);
    checkEq("stuff_nbytes", 32'(byteQ.size()), 32'd1);
    checkEq("stuff_byte", qByte(0), 32'hFF);
    checkEq("stuff_eof", 32'(eofCnt), 32'd1);
    checkEq("stuff_err", 32'(errCnt), 32'd0);

    // Twelve data bits: one byte then a 4-bit residue
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    for (int i = 0; i < 12; i++) sendBit(oddBits[i]);
    sendRaw(8'h7E);
    idle(12);
    checkEq("odd_nbytes", 32'(byteQ.size()), 32'd1);
    checkEq("odd_byte", qByte(0), 32'h3C);
    checkEq("odd_eof", 32'(eofCnt), 32'd1);
    checkEq("odd_err_with_eof", 32'(lastErr), 32'd1);
    checkEq("odd_err_alone", 32'(errAlone), 32'd0);

    // Abort after one byte
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'h55);
    sendBit(1'b0);
    repeat (7) sendBit(1'b1);
    checkEq("abort_t1", 32'(bus.Rx_AbortDetect), 32'd0);
    checkEq("abort_t1_valid", 32'(bus.Rx_ValidFrame), 32'd1);
    sendBit(1'b1);
    checkEq("abort_t2", 32'(bus.Rx_AbortDetect), 32'd1);
    checkEq("abort_t2_valid", 32'(bus.Rx_ValidFrame), 32'd1);
    sendBit(1'b1);
    checkEq("abort_t3", 32'(bus.Rx_AbortDetect), 32'd0);
    checkEq("abort_t3_valid", 32'(bus.Rx_ValidFrame), 32'd0);
    idle(10);
    checkEq("abort_eof", 32'(eofCnt), 32'd0);
    checkEq("abort_count", 32'(abortCnt), 32'd1);
    checkEq("abort_byte", qByte(0), 32'h55);

    // Repeated opening flags
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendRaw(8'h7E);
    sendRaw(8'h7E);
    sendData(8'h81);
    checkEq("rep_flags_open", 32'(flagCnt), 32'd3);
    checkEq("rep_eof_early", 32'(eofCnt), 32'd0);
    sendRaw(8'h7E);
    idle(12);
    checkEq("rep_flags", 32'(flagCnt), 32'd4);
    checkEq("rep_eof", 32'(eofCnt), 32'd1);
    checkEq("rep_nbytes", 32'(byteQ.size()), 32'd1);
    checkEq("rep_byte", qByte(0), 32'h81);
    checkEq("rep_size", 32'(lastSize), expSize(1));

    // Reset mid-byte, then a clean frame
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'hA5);
    sendBit(1'b0); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    Rst = 1'b1;
    #1;
    checkEq("midrst_valid", 32'(bus.Rx_ValidFrame), 32'd0);
    checkEq("midrst_data", 32'(bus.Rx_Data), 32'h00);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'h3C);
    sendRaw(8'h7E);
    idle(12);
    checkEq("midrst_eof", 32'(eofCnt), 32'd1);
    checkEq("midrst_nbytes", 32'(byteQ.size()), 32'd1);
    checkEq("midrst_byte", qByte(0), 32'h3C);

    // RxEN dropped mid-frame, then a clean frame
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'h5A);
    sendBit(1'b1);
    sendBit(1'b0);
    checkEq("en_valid_before", 32'(bus.Rx_ValidFrame), 32'd1);
    bus.RxEN = 1'b0;
    @(posedge Clk);
    #1;
    checkEq("en_valid_off", 32'(bus.Rx_ValidFrame), 32'd0);
    checkEq("en_pulses_off", 32'({bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte,
                                  bus.Rx_EoF, bus.Rx_FrameError}), 32'd0);
    @(posedge Clk);
    #1;
    bus.RxEN = 1'b1;
    clearCounts();
    idle(4);
    sendRaw(8'h7E);
    sendData(8'h42);
    sendRaw(8'h7E);
    idle(12);
    checkEq("en_eof", 32'(eofCnt), 32'd1);
    checkEq("en_nbytes", 32'(byteQ.size()), 32'd1);
    checkEq("en_byte", qByte(0), 32'h42);
    checkEq("en_err", 32'(errCnt), 32'd0);

    checkEq("flag_newbyte_overlap", 32'(overlapCnt), 32'd0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end
endmodule
